rf80386_fta_arbiter: RTL and testbench

Two-port bus arbiter that shares the single fta 128-bit master port of the rf80386 core between the instruction-cache line-fill path (port 0) and the CPU data path (port 1). Buffers one request per port, grants round-robin, retags each request's transaction channel, tracks the single outstanding transaction, handles retry (rty) with backoff and response timeout, and routes each response back to the originating port. Sits between the core/icache and the system fta bus.

---
 rtl/rf80386_fta_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_rf80386_fta_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf80386_fta_arbiter.sv
// Two-port fta bus arbiter: shares the rf80386 128-bit master port between the
// icache line-fill path (port 0) and the CPU data path (port 1).
package rf80386_fta_pkg;
   typedef enum logic [3:0] {
      CMD_NONE  = 4'd0,
      CMD_LOAD  = 4'd1,
      CMD_STORE = 4'd2
   } fta_cmd_t;

   typedef struct packed {
      logic [5:0] core;
      logic [2:0] channel;
      logic [7:0] tranid;
   } fta_tranid_t;

   typedef struct packed {
      fta_cmd_t     cmd;
      fta_tranid_t  tid;
      logic         cyc;
      logic         stb;
      logic         we;
      logic [15:0]  sel;
      logic [31:0]  padr;
      logic [127:0] data1;
   } fta_cmd_request128_t;

   typedef struct packed {
      fta_cmd_t     cmd;
      fta_tranid_t  tid;
      logic         ack;
      logic         rty;
      logic         err;
      logic [31:0]  adr;
      logic [127:0] dat;
   } fta_cmd_response128_t;
endpackage

module rf80386_fta_arbiter
   import rf80386_fta_pkg::*;
#(
   parameter logic [5:0]  CORENO   = 6'd1,
   parameter logic [2:0]  CH0      = 3'd1,
   parameter logic [2:0]  CH1      = 3'd2,
   parameter logic [4:0]  RTY_WAIT = 5'd8,
   parameter logic [15:0] TIMEOUT  = 16'd1023
)(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  fta_cmd_request128_t  s0_req,
   output fta_cmd_response128_t s0_resp,
   output logic                 s0_busy,
   input  fta_cmd_request128_t  s1_req,
   output fta_cmd_response128_t s1_resp,
   output logic                 s1_busy,
   output fta_cmd_request128_t  m_req,
   input  fta_cmd_response128_t m_resp
);

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_ISSUE       = 2'd1,
      ST_WAIT_RESP   = 2'd2,
      ST_RTY_BACKOFF = 2'd3
   } state_t;

   state_t               r_state;
   logic [1:0]           r_hold_v;
   fta_cmd_request128_t  r_hold_req [2];
   logic                 r_last_gnt;
   logic                 r_gnt;
   logic [15:0]          r_wait_cnt;
   logic [4:0]           r_rty_cnt;
   fta_cmd_request128_t  r_m_req;
   fta_cmd_response128_t r_s0_resp;
   fta_cmd_response128_t r_s1_resp;

   logic                 w_gnt;
   logic [1:0]           w_req_valid;
   logic [2:0]           w_exp_ch;
   logic                 w_match;
   fta_cmd_request128_t  w_issue_req;
   fta_cmd_response128_t w_ack_resp;
   fta_cmd_response128_t w_tout_resp;

   assign s0_busy = r_hold_v[0];
   assign s1_busy = r_hold_v[1];
   assign m_req   = r_m_req;
   assign s0_resp = r_s0_resp;
   assign s1_resp = r_s1_resp;

   // Grant choice, response matching and the retagged request/response images
   always_comb begin
      w_req_valid = {s1_req.cyc & s1_req.stb, s0_req.cyc & s0_req.stb};
      if (r_hold_v == 2'b11) begin
         w_gnt = ~r_last_gnt;
      end else if (r_hold_v[0]) begin
         w_gnt = 1'b0;
      end else begin
         w_gnt = 1'b1;
      end
      w_exp_ch = r_gnt ? CH1 : CH0;
      w_match  = (m_resp.ack | m_resp.rty) && (m_resp.tid.core == CORENO)
                 && (m_resp.tid.channel == w_exp_ch);

      w_issue_req             = r_hold_req[r_gnt];
      w_issue_req.tid.core    = CORENO;
      w_issue_req.tid.channel = w_exp_ch;

      // The requester only recognises its own channel number, so restore it.
      w_ack_resp             = m_resp;
      w_ack_resp.tid.channel = r_hold_req[r_gnt].tid.channel;

      w_tout_resp     = '0;
      w_tout_resp.cmd = r_hold_req[r_gnt].cmd;
      w_tout_resp.tid = r_hold_req[r_gnt].tid;
      w_tout_resp.ack = 1'b1;
      w_tout_resp.err = 1'b1;
   end

   // Holding registers, arbitration FSM and registered bus/port outputs
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state       <= ST_IDLE;
         r_hold_v      <= 2'b00;
         r_hold_req[0] <= '0;
         r_hold_req[1] <= '0;
         r_last_gnt    <= 1'b1;
         r_gnt         <= 1'b0;
         r_wait_cnt    <= 16'd0;
         r_rty_cnt     <= 5'd0;
         r_m_req       <= '0;
         r_s0_resp     <= '0;
         r_s1_resp     <= '0;
      end else begin
         r_m_req   <= '0;
         r_s0_resp <= '0;
         r_s1_resp <= '0;
         if (w_req_valid[0] && !r_hold_v[0]) begin
            r_hold_v[0]   <= 1'b1;
            r_hold_req[0] <= s0_req;
         end
         if (w_req_valid[1] && !r_hold_v[1]) begin
            r_hold_v[1]   <= 1'b1;
            r_hold_req[1] <= s1_req;
         end
         case (r_state)
            ST_IDLE: begin
               if (|r_hold_v) begin
                  r_gnt   <= w_gnt;
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_m_req    <= w_issue_req;
               r_last_gnt <= r_gnt;
               r_wait_cnt <= 16'd0;
               r_state    <= ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
               if (w_match && m_resp.ack) begin
                  if (r_gnt) r_s1_resp <= w_ack_resp;
                  else       r_s0_resp <= w_ack_resp;
                  r_hold_v[r_gnt] <= 1'b0;
                  r_state         <= ST_IDLE;
               end else if (w_match) begin
                  r_rty_cnt <= 5'd0;
                  r_state   <= ST_RTY_BACKOFF;
               end else if (r_wait_cnt == TIMEOUT) begin
                  if (r_gnt) r_s1_resp <= w_tout_resp;
                  else       r_s0_resp <= w_tout_resp;
                  r_hold_v[r_gnt] <= 1'b0;
                  r_state         <= ST_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 16'd1;
               end
            end
            ST_RTY_BACKOFF: begin
               if (r_rty_cnt == RTY_WAIT - 5'd1) begin
                  r_state <= ST_ISSUE;
               end else begin
                  r_rty_cnt <= r_rty_cnt + 5'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rf80386_fta_arbiter.sv
// Directed self-checking bench for rf80386_fta_arbiter.
module tb_rf80386_fta_arbiter;
   import rf80386_fta_pkg::*;

   localparam logic [2:0] CH0 = 3'd1;
   localparam logic [2:0] CH1 = 3'd2;

   logic                 clk;
   logic                 rst_n;
   fta_cmd_request128_t  s0_req, s1_req, m_req;
   fta_cmd_response128_t s0_resp, s1_resp, m_resp;
   logic                 s0_busy, s1_busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_s0_ack = 0;
   int n_s1_ack = 0;
   int n_mreq   = 0;

   rf80386_fta_arbiter dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .s0_req  (s0_req),
      .s0_resp (s0_resp),
      .s0_busy (s0_busy),
      .s1_req  (s1_req),
      .s1_resp (s1_resp),
      .s1_busy (s1_busy),
      .m_req   (m_req),
      .m_resp  (m_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (s0_resp.ack) n_s0_ack <= n_s0_ack + 1;
      if (s1_resp.ack) n_s1_ack <= n_s1_ack + 1;
      if (m_req.cyc)   n_mreq   <= n_mreq + 1;
   end

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic fta_cmd_request128_t mk_req(input logic [7:0] tranid, input logic [2:0] ch,
                                                  input logic [31:0] adr);
      fta_cmd_request128_t r;
      r             = '0;
      r.cmd         = CMD_LOAD;
      r.cyc         = 1'b1;
      r.stb         = 1'b1;
      r.sel         = 16'hFFFF;
      r.padr        = adr;
      r.tid.core    = 6'd9;
      r.tid.channel = ch;
      r.tid.tranid  = tranid;
      return r;
   endfunction

   function automatic fta_cmd_response128_t mk_resp(input logic [5:0] core, input logic [2:0] ch,
                                                    input logic [7:0] tranid, input logic ack,
                                                    input logic rty, input logic [127:0] dat);
      fta_cmd_response128_t r;
      r             = '0;
      r.cmd         = CMD_LOAD;
      r.tid.core    = core;
      r.tid.channel = ch;
      r.tid.tranid  = tranid;
      r.ack         = ack;
      r.rty         = rty;
      r.dat         = dat;
      return r;
   endfunction

   task automatic wait_issue(input int maxc, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         step();
         if (m_req.cyc) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Wait for the next issue, check its tag, ack it and check the routed response.
   task automatic serve(input string tag, input logic port, input logic [7:0] tranid,
                        input logic [2:0] orig_ch, input logic [127:0] dat);
      logic       ok;
      logic [2:0] ch;
      ch = port ? CH1 : CH0;
      wait_issue(20, ok);
      check_val({tag, "_issue"}, 128'(ok), 128'(1'b1));
      check_val({tag, "_ch"}, 128'(m_req.tid.channel), 128'(ch));
      m_resp = mk_resp(6'd1, ch, tranid, 1'b1, 1'b0, dat);
      step();
      m_resp = '0;
      if (port) begin
         check_val({tag, "_ack"}, 128'(s1_resp.ack), 128'(1'b1));
         check_val({tag, "_dat"}, s1_resp.dat, dat);
         check_val({tag, "_rch"}, 128'(s1_resp.tid.channel), 128'(orig_ch));
      end else begin
         check_val({tag, "_ack"}, 128'(s0_resp.ack), 128'(1'b1));
         check_val({tag, "_dat"}, s0_resp.dat, dat);
         check_val({tag, "_rch"}, 128'(s0_resp.tid.channel), 128'(orig_ch));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic ok;
      int   k, a0, a1, i0, t0;
      s0_req = '0;
      s1_req = '0;
      m_resp = '0;
      rst_n  = 1'b0;
      repeat (3) step();
      check_val("rst_mreq", 128'(m_req), 128'(0));
      check_val("rst_s0resp", 128'(s0_resp), 128'(0));
      check_val("rst_s1resp", 128'(s1_resp), 128'(0));
      check_val("rst_busy", 128'({s1_busy, s0_busy}), 128'(2'b00));
      rst_n = 1'b1;
      step();

      // Single port-1 read, ack three cycles after issue
      s1_req = mk_req(8'h05, 3'd7, 32'h0000_1000);
      step();
      s1_req = '0;
      check_val("t1_busy_cap", 128'(s1_busy), 128'(1'b1));
      step();
      check_val("t1_no_early", 128'(m_req.cyc), 128'(1'b0));
      step();
      check_val("t1_issue", 128'(m_req.cyc), 128'(1'b1));
      check_val("t1_core", 128'(m_req.tid.core), 128'(6'd1));
      check_val("t1_ch", 128'(m_req.tid.channel), 128'(CH1));
      check_val("t1_tran", 128'(m_req.tid.tranid), 128'(8'h05));
      check_val("t1_adr", 128'(m_req.padr), 128'(32'h0000_1000));
      step();
      check_val("t1_one_cyc", 128'(m_req.cyc), 128'(1'b0));
      step();
      check_val("t1_busy_wait", 128'(s1_busy), 128'(1'b1));
      m_resp = mk_resp(6'd1, CH1, 8'h05, 1'b1, 1'b0, 128'h1234);
      step();
      m_resp = '0;
      check_val("t1_ack", 128'(s1_resp.ack), 128'(1'b1));
      check_val("t1_dat", s1_resp.dat, 128'h1234);
      check_val("t1_rch", 128'(s1_resp.tid.channel), 128'(3'd7));
      check_val("t1_busy_drop", 128'(s1_busy), 128'(1'b0));
      check_val("t1_s0_quiet", 128'(s0_resp.ack), 128'(1'b0));
      step();
      check_val("t1_resp_one", 128'(s1_resp.ack), 128'(1'b0));

      // Simultaneous requests after reset alternate 0,1,0,1
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int r = 0; r < 2; r++) begin
         s0_req = mk_req(8'h10, 3'd3, 32'h0000_2000);
         s1_req = mk_req(8'h20, 3'd5, 32'h0000_3000);
         step();
         s0_req = '0;
         s1_req = '0;
         check_val("t2_both_busy", 128'({s1_busy, s0_busy}), 128'(2'b11));
         serve("t2_p0", 1'b0, 8'h10, 3'd3, 128'hA0 + 128'(r));
         check_val("t2_p1_held", 128'(s1_busy), 128'(1'b1));
         serve("t2_p1", 1'b1, 8'h20, 3'd5, 128'hB0 + 128'(r));
      end

      // Port 0 retried twice, then acked
      s0_req = mk_req(8'h33, 3'd4, 32'h0000_4000);
      step();
      s0_req = '0;
      a0 = n_s0_ack;
      i0 = n_mreq;
      wait_issue(20, ok);
      check_val("t3_issue", 128'(ok), 128'(1'b1));
      for (int r = 0; r < 2; r++) begin
         m_resp = mk_resp(6'd1, CH0, 8'h33, 1'b0, 1'b1, 128'h0);
         step();
         m_resp = '0;
         k = 0;
         for (int i = 0; i < 30; i++) begin
            step();
            k++;
            if (m_req.cyc) break;
         end
         check_val("t3_rty_gap", 128'(k), 128'(9));
      end
      m_resp = mk_resp(6'd1, CH0, 8'h33, 1'b1, 1'b0, 128'hABCD);
      step();
      m_resp = '0;
      check_val("t3_ack", 128'(s0_resp.ack), 128'(1'b1));
      check_val("t3_dat", s0_resp.dat, 128'hABCD);
      step();
      step();
      check_val("t3_issues", 128'(n_mreq - i0), 128'(3));
      check_val("t3_resps", 128'(n_s0_ack - a0), 128'(1));

      // Port 1 times out, then port 0 proceeds
      s1_req = mk_req(8'h44, 3'd6, 32'h0000_5000);
      step();
      s1_req = '0;
      wait_issue(20, ok);
      check_val("t4_issue", 128'(ok), 128'(1'b1));
      t0 = cyc;
      for (int i = 0; i < 1100; i++) begin
         step();
         if (s1_resp.ack) break;
      end
      check_val("t4_ack", 128'(s1_resp.ack), 128'(1'b1));
      check_val("t4_err", 128'(s1_resp.err), 128'(1'b1));
      check_val("t4_dat", s1_resp.dat, 128'h0);
      check_val("t4_tran", 128'(s1_resp.tid.tranid), 128'(8'h44));
      check_val("t4_rch", 128'(s1_resp.tid.channel), 128'(3'd6));
      check_val("t4_busy", 128'(s1_busy), 128'(1'b0));
      check_val("t4_window", 128'((cyc - t0 >= 1023) && (cyc - t0 <= 1026)), 128'(1'b1));
      s0_req = mk_req(8'h45, 3'd2, 32'h0000_5100);
      step();
      s0_req = '0;
      serve("t4_next", 1'b0, 8'h45, 3'd2, 128'h5555);

      // Foreign core and wrong-channel responses are ignored
      s0_req = mk_req(8'h55, 3'd1, 32'h0000_6000);
      step();
      s0_req = '0;
      a0 = n_s0_ack;
      wait_issue(20, ok);
      check_val("t5_issue", 128'(ok), 128'(1'b1));
      m_resp = mk_resp(6'd2, CH0, 8'h55, 1'b1, 1'b0, 128'hDEAD);
      step();
      m_resp = mk_resp(6'd1, CH1, 8'h55, 1'b1, 1'b0, 128'hBEEF);
      step();
      m_resp = '0;
      step();
      check_val("t5_ignored", 128'(n_s0_ack - a0), 128'(0));
      check_val("t5_busy", 128'(s0_busy), 128'(1'b1));
      m_resp = mk_resp(6'd1, CH0, 8'h55, 1'b1, 1'b1, 128'h7777);
      step();
      m_resp = '0;
      check_val("t5_ack_rty", 128'(s0_resp.ack), 128'(1'b1));
      check_val("t5_dat", s0_resp.dat, 128'h7777);

      // Reset while waiting; the late ack must not be forwarded
      s1_req = mk_req(8'h66, 3'd3, 32'h0000_7000);
      step();
      s1_req = '0;
      a1 = n_s1_ack;
      wait_issue(20, ok);
      check_val("t6_issue", 128'(ok), 128'(1'b1));
      step();
      rst_n = 1'b0;
      step();
      check_val("t6_rst_mreq", 128'(m_req), 128'(0));
      check_val("t6_rst_busy", 128'({s1_busy, s0_busy}), 128'(2'b00));
      rst_n  = 1'b1;
      m_resp = mk_resp(6'd1, CH1, 8'h66, 1'b1, 1'b0, 128'h9999);
      step();
      m_resp = '0;
      step();
      step();
      check_val("t6_no_resp", 128'(n_s1_ack - a1), 128'(0));
      check_val("t6_quiet", 128'({m_req.cyc, s1_busy, s1_resp.ack}), 128'(3'b000));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
